// File: rtl/imsic_pkg.sv
// imsic_pkg: shared register addresses, file indices and privilege encodings for the IMSIC responder
package imsic_pkg;
  localparam logic [31:0] EIDELIVERY  = 32'h70;
  localparam logic [31:0] EITHRESHOLD = 32'h72;
  localparam logic [31:0] EIP0        = 32'h80;
  localparam logic [31:0] EIE0        = 32'hC0;
  typedef enum logic [1:0] {
    FILE_M   = 2'd0,
    FILE_S   = 2'd1,
    FILE_VS0 = 2'd2
  } file_e;
  localparam logic [1:0] PRIV_U  = 2'b00;
  localparam logic [1:0] PRIV_S  = 2'b01;
  localparam logic [1:0] PRIV_VS = 2'b10;
  localparam logic [1:0] PRIV_M  = 2'b11;
endpackage

// File: rtl/imsic_top_finder.sv
// imsic_top_finder: lowest enabled pending identity of one interrupt file, gated by delivery and threshold
module imsic_top_finder #(
  parameter int NrSources  = 64,
  parameter int NrSourcesW = $clog2(NrSources)
) (
  input  logic [NrSources-1:0]  eip_i,
  input  logic [NrSources-1:0]  eie_i,
  input  logic [NrSourcesW-1:0] thr_i,
  input  logic                  del_i,
  output logic [NrSourcesW-1:0] id_o
);
  logic [NrSources-1:0] pend;
  // identity 0 is never valid, so it is masked out; scanning downwards leaves the lowest qualifying id
  always_comb begin
    pend = eip_i & eie_i & ~NrSources'(1);
    id_o = '0;
    for (int i = NrSources - 1; i >= 0; i--)
      if (del_i && pend[i] && (thr_i == '0 || NrSourcesW'(i) < thr_i)) id_o = NrSourcesW'(i);
  end
endmodule

// File: rtl/imsic_intp_file_responder.sv
// imsic_intp_file_responder: M/S/VS interrupt files answering indirect CSR accesses, claims and MSI writes
module imsic_intp_file_responder
  import imsic_pkg::*;
#(
  parameter int NrSources     = 64,
  parameter int NrVSIntpFiles = 1,
  localparam int NrSourcesW   = $clog2(NrSources),
  localparam int VgeinW       = $clog2(NrVSIntpFiles + 1),
  localparam int NrIntpFiles  = 2 + NrVSIntpFiles,
  localparam int FileW        = $clog2(NrIntpFiles)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [1:0]                        priv_lvl_i,
  input  logic [VgeinW:0]                   vgein_i,
  input  logic [31:0]                       addr_i,
  input  logic [31:0]                       data_i,
  input  logic                              we_i,
  input  logic                              claim_i,
  output logic [31:0]                       data_o,
  output logic                              exception_o,
  output logic [NrIntpFiles*NrSourcesW-1:0] xtopei_o,
  output logic [NrIntpFiles-1:0]            irq_o,
  input  logic                              msi_valid_i,
  input  logic [FileW-1:0]                  msi_file_i,
  input  logic [NrSourcesW:0]               msi_id_i,
  output logic                              msi_ready_o
);
  localparam int NrWords = NrSources / 32;

  logic [NrSources-1:0]              eip_q [NrIntpFiles];
  logic [NrSources-1:0]              eip_d [NrIntpFiles];
  logic [NrSources-1:0]              eie_q [NrIntpFiles];
  logic [NrSources-1:0]              eie_d [NrIntpFiles];
  logic [NrSourcesW-1:0]             thr_q [NrIntpFiles];
  logic [NrSourcesW-1:0]             thr_d [NrIntpFiles];
  logic [NrSourcesW-1:0]             top   [NrIntpFiles];
  logic [NrIntpFiles-1:0]            del_q, del_d, irq_q, irq_d;
  logic [NrIntpFiles*NrSourcesW-1:0] xtopei_q, xtopei_d;
  logic                              ready_q;
  logic                              file_ok, is_del, is_thr, is_eip, is_eie, exc, wr, clm, msi_ok;
  logic [FileW-1:0]                  sel;
  logic [5:0]                        off;
  logic [NrSources-1:0]              wmask, wdata, msi_set;
  logic [31:0]                       rd;

  // access decode: target file, register, legality and read mux
  always_comb begin
    off     = addr_i[5:0];
    file_ok = priv_lvl_i == PRIV_M || priv_lvl_i == PRIV_S ||
              (priv_lvl_i == PRIV_VS && vgein_i != '0 && vgein_i <= (VgeinW+1)'(NrVSIntpFiles));
    sel     = priv_lvl_i == PRIV_M ? FileW'(FILE_M) :
              priv_lvl_i == PRIV_S ? FileW'(FILE_S) :
              FileW'(FILE_VS0) + FileW'(vgein_i) - FileW'(1);
    is_del  = addr_i == EIDELIVERY;
    is_thr  = addr_i == EITHRESHOLD;
    is_eip  = addr_i[31:6] == EIP0[31:6] && {1'b0, off} < 7'(NrWords);
    is_eie  = addr_i[31:6] == EIE0[31:6] && {1'b0, off} < 7'(NrWords);
    exc     = !file_ok || !(is_del || is_thr || is_eip || is_eie) || (we_i && claim_i);
    wr      = we_i && !exc;
    clm     = claim_i && !exc;
    rd      = is_del ? {31'b0, del_q[sel]} :
              is_thr ? 32'(thr_q[sel]) :
              is_eip ? 32'(eip_q[sel] >> {off, 5'b0}) :
              32'(eie_q[sel] >> {off, 5'b0});
    data_o      = exc ? '0 : rd;
    exception_o = exc;
    wmask   = NrSources'(32'hFFFF_FFFF) << {off, 5'b0};
    wdata   = {NrWords{data_i}} & ~NrSources'(1);
    msi_ok  = msi_valid_i && ready_q && msi_id_i != '0 &&
              msi_id_i < (NrSourcesW+1)'(NrSources) && {1'b0, msi_file_i} < (FileW+1)'(NrIntpFiles);
    msi_set = NrSources'(1) << msi_id_i[NrSourcesW-1:0];
  end

  // next-state merge: CSR write, then claim clear, then MSI set so the MSI wins on the same bit
  always_comb begin
    del_d = del_q;
    for (int f = 0; f < NrIntpFiles; f++) begin
      eip_d[f] = wr && sel == FileW'(f) && is_eip ? (eip_q[f] & ~wmask) | (wdata & wmask) : eip_q[f];
      eip_d[f] = clm && sel == FileW'(f) ? eip_d[f] & ~(NrSources'(1) << top[f]) : eip_d[f];
      eip_d[f] = msi_ok && msi_file_i == FileW'(f) ? eip_d[f] | msi_set : eip_d[f];
      eie_d[f] = wr && sel == FileW'(f) && is_eie ? (eie_q[f] & ~wmask) | (wdata & wmask) : eie_q[f];
      thr_d[f] = wr && sel == FileW'(f) && is_thr ? data_i[NrSourcesW-1:0] : thr_q[f];
      del_d[f] = wr && sel == FileW'(f) && is_del ? data_i[0] : del_q[f];
    end
  end

  for (genvar g = 0; g < NrIntpFiles; g++) begin : g_find
    imsic_top_finder #(.NrSources(NrSources)) u_find (
      .eip_i(eip_q[g]),
      .eie_i(eie_q[g]),
      .thr_i(thr_q[g]),
      .del_i(del_q[g]),
      .id_o (top[g])
    );
  end

  // flatten per-file top identities for the registered hart outputs
  always_comb begin
    xtopei_d = '0;
    irq_d    = '0;
    for (int f = 0; f < NrIntpFiles; f++) begin
      xtopei_d[f*NrSourcesW +: NrSourcesW] = top[f];
      irq_d[f] = |top[f];
    end
  end

  // state and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int f = 0; f < NrIntpFiles; f++) begin
        eip_q[f] <= '0;
        eie_q[f] <= '0;
        thr_q[f] <= '0;
      end
      del_q    <= '0;
      xtopei_q <= '0;
      irq_q    <= '0;
      ready_q  <= 1'b0;
    end else begin
      for (int f = 0; f < NrIntpFiles; f++) begin
        eip_q[f] <= eip_d[f];
        eie_q[f] <= eie_d[f];
        thr_q[f] <= thr_d[f];
      end
      del_q    <= del_d;
      xtopei_q <= xtopei_d;
      irq_q    <= irq_d;
      ready_q  <= 1'b1;
    end
  end

  assign xtopei_o    = xtopei_q;
  assign irq_o       = irq_q;
  assign msi_ready_o = ready_q;
endmodule

// File: tb/tb_imsic_intp_file_responder.sv
// tb_imsic_intp_file_responder: directed checks of CSR access, priority, claim, MSI and illegal access handling
module tb_imsic_intp_file_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  priv = 2'b11;
  logic [1:0]  vgein = '0;
  logic [31:0] addr = 32'h70;
  logic [31:0] wdat = '0;
  logic        we = 1'b0;
  logic        claim = 1'b0;
  logic [31:0] data_o;
  logic        exc_o;
  logic [17:0] xtopei_o;
  logic [2:0]  irq_o;
  logic        msi_valid = 1'b0;
  logic [1:0]  msi_file = '0;
  logic [6:0]  msi_id = '0;
  logic        msi_ready;
  logic [5:0]  xt [3];
  int          vectors = 0;
  int          fails = 0;

  imsic_intp_file_responder dut (
    .clk_i(clk), .rst_i(rst), .priv_lvl_i(priv), .vgein_i(vgein), .addr_i(addr), .data_i(wdat),
    .we_i(we), .claim_i(claim), .data_o(data_o), .exception_o(exc_o), .xtopei_o(xtopei_o),
    .irq_o(irq_o), .msi_valid_i(msi_valid), .msi_file_i(msi_file), .msi_id_i(msi_id),
    .msi_ready_o(msi_ready)
  );

  always #5 clk = ~clk;

  always_comb for (int f = 0; f < 3; f++) xt[f] = xtopei_o[f*6 +: 6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] p, input logic [1:0] v, input logic [31:0] a,
                    input logic [31:0] exp, input string tag);
    priv = p; vgein = v; addr = a;
    #1;
    chk(tag, data_o, exp);
  endtask

  task automatic wr(input logic [1:0] p, input logic [1:0] v, input logic [31:0] a, input logic [31:0] d);
    priv = p; vgein = v; addr = a; wdat = d; we = 1'b1;
    tick;
    we = 1'b0;
  endtask

  task automatic msi(input logic [1:0] f, input logic [6:0] id);
    msi_valid = 1'b1; msi_file = f; msi_id = id;
    tick;
    msi_valid = 1'b0;
  endtask

  task automatic ill(input logic [1:0] p, input logic [1:0] v, input logic [31:0] a, input string tag);
    priv = p; vgein = v; addr = a;
    #1;
    chk({tag, "_exc"}, 32'(exc_o), 32'd1);
    chk({tag, "_data"}, data_o, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(msi_ready), 32'd0);
    chk("rst_xtopei", 32'(xtopei_o), 32'd0);
    chk("rst_irq", 32'(irq_o), 32'd0);
    chk("rst_data", data_o, 32'd0);
    rst = 1'b0;
    tick;
    chk("ready_after_rst", 32'(msi_ready), 32'd1);
    rd(2'b11, 2'd0, 32'h72, 32'd0, "rst_thr");
    rd(2'b11, 2'd0, 32'h80, 32'd0, "rst_eip0");
    rd(2'b01, 2'd0, 32'hC1, 32'd0, "rst_eie1");
    // M file basic delivery
    wr(2'b11, 2'd0, 32'h70, 32'd1);
    wr(2'b11, 2'd0, 32'hC0, 32'hFFFF_FFFE);
    msi(2'd0, 7'd5);
    chk("m_xtopei_lag", 32'(xt[0]), 32'd0);
    tick;
    chk("m_xtopei", 32'(xt[0]), 32'd5);
    chk("m_irq", 32'(irq_o), 32'b001);
    rd(2'b11, 2'd0, 32'h80, 32'h20, "m_eip0");
    rd(2'b11, 2'd0, 32'hC0, 32'hFFFF_FFFE, "m_eie0");
    // S file priority and threshold
    wr(2'b01, 2'd0, 32'h70, 32'd1);
    wr(2'b01, 2'd0, 32'hC0, 32'hFFFF_FFFE);
    msi(2'd1, 7'd9);
    msi(2'd1, 7'd3);
    wr(2'b01, 2'd0, 32'h72, 32'd4);
    tick;
    chk("s_thr4", 32'(xt[1]), 32'd3);
    wr(2'b01, 2'd0, 32'h72, 32'd3);
    tick;
    chk("s_thr3", 32'(xt[1]), 32'd0);
    chk("s_thr3_irq", 32'(irq_o), 32'b001);
    wr(2'b01, 2'd0, 32'h72, 32'd0);
    tick;
    chk("s_thr0", 32'(xt[1]), 32'd3);
    chk("s_thr0_irq", 32'(irq_o), 32'b011);
    rd(2'b01, 2'd0, 32'h80, 32'h208, "s_eip0");
    // claim
    priv = 2'b01; addr = 32'h70; claim = 1'b1;
    #1;
    chk("claim_data", data_o, 32'd1);
    chk("claim_exc", 32'(exc_o), 32'd0);
    tick;
    claim = 1'b0;
    rd(2'b01, 2'd0, 32'h80, 32'h200, "claim_eip");
    tick;
    chk("claim_next_top", 32'(xt[1]), 32'd9);
    msi(2'd1, 7'd3);
    tick;
    chk("repend_top", 32'(xt[1]), 32'd3);
    priv = 2'b01; addr = 32'h70; claim = 1'b1;
    msi_valid = 1'b1; msi_file = 2'd1; msi_id = 7'd3;
    tick;
    claim = 1'b0; msi_valid = 1'b0;
    rd(2'b01, 2'd0, 32'h80, 32'h208, "claim_msi_eip");
    tick;
    chk("claim_msi_top", 32'(xt[1]), 32'd3);
    // CSR eip write racing an MSI on another bit of the same word
    priv = 2'b01; addr = 32'h80; wdat = 32'd0; we = 1'b1;
    msi_valid = 1'b1; msi_file = 2'd1; msi_id = 7'd9;
    tick;
    we = 1'b0; msi_valid = 1'b0;
    rd(2'b01, 2'd0, 32'h80, 32'h200, "wr_msi_eip");
    tick;
    chk("wr_msi_top", 32'(xt[1]), 32'd9);
    // illegal accesses
    ill(2'b00, 2'd0, 32'h70, "priv00");
    ill(2'b10, 2'd0, 32'h70, "vgein0");
    ill(2'b10, 2'd2, 32'h70, "vgein2");
    ill(2'b11, 2'd0, 32'h71, "addr71");
    ill(2'b11, 2'd0, 32'h82, "addr82");
    ill(2'b11, 2'd0, 32'h73, "addr73");
    ill(2'b01, 2'd0, 32'hC2, "addrC2");
    priv = 2'b01; addr = 32'h70; wdat = 32'd0; we = 1'b1; claim = 1'b1;
    #1;
    chk("we_claim_exc", 32'(exc_o), 32'd1);
    tick;
    we = 1'b0; claim = 1'b0;
    rd(2'b01, 2'd0, 32'h70, 32'd1, "we_claim_del");
    rd(2'b01, 2'd0, 32'h80, 32'h200, "we_claim_eip");
    wr(2'b00, 2'd0, 32'h70, 32'd0);
    wr(2'b10, 2'd0, 32'h70, 32'd0);
    wr(2'b11, 2'd0, 32'h82, 32'hFFFF_FFFF);
    rd(2'b11, 2'd0, 32'h70, 32'd1, "ill_wr_mdel");
    rd(2'b01, 2'd0, 32'h70, 32'd1, "ill_wr_sdel");
    rd(2'b11, 2'd0, 32'h81, 32'd0, "ill_wr_meip1");
    // VS file
    msi(2'd2, 7'd40);
    wr(2'b10, 2'd1, 32'h70, 32'd1);
    wr(2'b10, 2'd1, 32'hC1, 32'h100);
    tick;
    chk("vs_top", 32'(xt[2]), 32'd40);
    chk("vs_m_top", 32'(xt[0]), 32'd5);
    chk("vs_s_top", 32'(xt[1]), 32'd9);
    chk("vs_irq", 32'(irq_o), 32'b111);
    rd(2'b10, 2'd1, 32'h81, 32'h100, "vs_eip1");
    rd(2'b11, 2'd0, 32'hC1, 32'd0, "vs_m_eie1");
    // dropped MSIs still handshake
    msi(2'd3, 7'd5);
    msi(2'd2, 7'd64);
    msi(2'd0, 7'd0);
    chk("drop_ready", 32'(msi_ready), 32'd1);
    rd(2'b10, 2'd1, 32'h80, 32'd0, "drop_vs_eip0");
    rd(2'b10, 2'd1, 32'h81, 32'h100, "drop_vs_eip1");
    rd(2'b11, 2'd0, 32'h80, 32'h20, "drop_m_eip0");
    // threshold masking, bit 0 of eip, strict threshold boundary
    wr(2'b11, 2'd0, 32'h72, 32'hFFFF_FFC7);
    rd(2'b11, 2'd0, 32'h72, 32'd7, "thr_mask");
    wr(2'b11, 2'd0, 32'h80, 32'h21);
    rd(2'b11, 2'd0, 32'h80, 32'h20, "eip_bit0");
    wr(2'b11, 2'd0, 32'h72, 32'd5);
    tick;
    chk("thr_eq_id", 32'(xt[0]), 32'd0);
    // reset in the middle of a write
    priv = 2'b11; addr = 32'h70; wdat = 32'd0; we = 1'b1;
    rst = 1'b1;
    #1;
    chk("midrst_irq", 32'(irq_o), 32'd0);
    chk("midrst_ready", 32'(msi_ready), 32'd0);
    tick;
    we = 1'b0; rst = 1'b0;
    rd(2'b11, 2'd0, 32'h70, 32'd0, "midrst_mdel");
    rd(2'b10, 2'd1, 32'h81, 32'd0, "midrst_vseip");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
